// File: rtl/nbody_force_engine.sv
// nbody_force_engine: naive O(N^2) 2-D gravitational force pass over N bodies
// held in an internal 80-bit x 32768-word RAM. Each word holds
// {m[15:0], x[15:0], y[15:0], fx[15:0], fy[15:0]}. A pass reads m,x,y of every
// body and rewrites only the force field. A debug read port exposes the RAM
// whenever the engine is idle.
module nbody_force_engine #(
  parameter int unsigned N        = 2,
  parameter int unsigned EPS      = 1,
  parameter              MEM_INIT = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [14:0] dbg_rdaddr,
  output logic [79:0] dbg_q
);

  localparam logic [15:0] LAST = 16'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_I,
    S_RD_J,
    S_CALC,
    S_ACC,
    S_WR,
    S_DONE
  } state_t;

  state_t state;

  // Body storage and its single registered read port
  logic [79:0] mem [0:32767];
  logic [79:0] q;
  logic [14:0] rd_addr;

  // Write port, registered so nothing is written during reset
  logic        we;
  logic [14:0] waddr;
  logic [79:0] wdata;

  // Loop indices and the latched "i" body
  logic [15:0]        i_idx;
  logic [15:0]        j_idx;
  logic               load_i;
  logic [15:0]        mi;
  logic signed [15:0] xi;
  logic signed [15:0] yi;

  // Pair terms registered in CALC, consumed in ACC
  logic signed [16:0] dx_r;
  logic signed [16:0] dy_r;
  logic [34:0]        r2_r;
  logic [31:0]        p_r;
  logic               skip_r;

  logic signed [47:0] fxa;
  logic signed [47:0] fya;

  // Combinational pair arithmetic
  logic signed [16:0] dx_c;
  logic signed [16:0] dy_c;
  logic signed [33:0] sqx_c;
  logic signed [33:0] sqy_c;
  logic [34:0]        r2_c;
  logic [31:0]        p_c;
  logic signed [49:0] numx_c;
  logic signed [49:0] numy_c;
  logic signed [35:0] den_c;
  logic signed [49:0] qx_c;
  logic signed [49:0] qy_c;
  logic               busy;

  initial begin
    for (int unsigned k = 0; k < 32768; k++)
      mem[k] = '0;
  end

  function automatic logic [15:0] sat16(input logic signed [47:0] v);
    if (v > 48'sd32767)
      return 16'h7fff;
    else if (v < -48'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  // Read-port address mux: engine owns the port while a pass is running
  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
    if (!busy)
      rd_addr = dbg_rdaddr;
    else if (state == S_RD_I)
      rd_addr = i_idx[14:0];
    else
      rd_addr = j_idx[14:0];
  end

  // RAM write and registered read
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    q <= mem[rd_addr];
  end

  assign dbg_q = q;

  // Pair terms from body j (on q) against the latched body i
  always_comb begin
    dx_c   = {q[63], q[63:48]} - {xi[15], xi};
    dy_c   = {q[47], q[47:32]} - {yi[15], yi};
    sqx_c  = dx_c * dx_c;
    sqy_c  = dy_c * dy_c;
    r2_c   = 35'($unsigned(sqx_c)) + 35'($unsigned(sqy_c)) + 35'(EPS);
    p_c    = q[79:64] * mi;
    numx_c = $signed({1'b0, p_r}) * dx_r;
    numy_c = $signed({1'b0, p_r}) * dy_r;
    den_c  = $signed({1'b0, r2_r});
    qx_c   = numx_c / den_c;
    qy_c   = numy_c / den_c;
  end

  // Control FSM with datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      i_idx  <= '0;
      j_idx  <= '0;
      load_i <= 1'b0;
      mi     <= '0;
      xi     <= '0;
      yi     <= '0;
      dx_r   <= '0;
      dy_r   <= '0;
      r2_r   <= '0;
      p_r    <= '0;
      skip_r <= 1'b0;
      fxa    <= '0;
      fya    <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_RD_I;
            done  <= 1'b0;
            i_idx <= '0;
          end
        end
        S_RD_I: begin
          fxa    <= '0;
          fya    <= '0;
          j_idx  <= '0;
          load_i <= 1'b1;
          state  <= S_RD_J;
        end
        // q still carries body i on the first RD_J after RD_I
        S_RD_J: begin
          if (load_i) begin
            mi <= q[79:64];
            xi <= q[63:48];
            yi <= q[47:32];
          end
          load_i <= 1'b0;
          state  <= S_CALC;
        end
        S_CALC: begin
          dx_r   <= dx_c;
          dy_r   <= dy_c;
          r2_r   <= r2_c;
          p_r    <= p_c;
          skip_r <= (j_idx == i_idx);
          state  <= S_ACC;
        end
        S_ACC: begin
          if (!skip_r) begin
            fxa <= fxa + qx_c[47:0];
            fya <= fya + qy_c[47:0];
          end
          if (j_idx < LAST) begin
            j_idx <= j_idx + 16'd1;
            state <= S_RD_J;
          end else begin
            state <= S_WR;
          end
        end
        S_WR: begin
          we    <= 1'b1;
          waddr <= i_idx[14:0];
          wdata <= {mi, xi, yi, sat16(fxa), sat16(fya)};
          if (i_idx < LAST) begin
            i_idx <= i_idx + 16'd1;
            state <= S_RD_I;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbody_force_engine.sv
// Testbench for nbody_force_engine: two instances (N=2 and N=3), bodies preloaded
// into the RAM, results read back through the debug port and compared against a
// plain-arithmetic force model.
module tb_nbody_force_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        done_a, done_b;
  logic [14:0] addr_a, addr_b;
  logic [79:0] q_a, q_b;

  int checks = 0;
  int errors = 0;

  int bm [3];
  int bx [3];
  int by [3];

  always #5 clk = ~clk;

  nbody_force_engine #(.N(2), .EPS(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .done(done_a),
    .dbg_rdaddr(addr_a), .dbg_q(q_a)
  );

  nbody_force_engine #(.N(3), .EPS(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .done(done_b),
    .dbg_rdaddr(addr_b), .dbg_q(q_b)
  );

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int u);
    return (u == 0) ? done_a : done_b;
  endfunction

  task automatic set_start(input int u, input logic v);
    if (u == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_body(input int k, input int m, input int x, input int y);
    bm[k] = m; bx[k] = x; by[k] = y;
  endtask

  // Preload bodies with junk in the force field so the pass must overwrite it
  task automatic load(input int u, input int n);
    logic [79:0] w;
    logic [15:0] m16, x16, y16;
    for (int k = 0; k < n; k++) begin
      m16 = bm[k][15:0];
      x16 = bx[k][15:0];
      y16 = by[k][15:0];
      w = {m16, x16, y16, $urandom()};
      if (u == 0) dut_a.mem[k] = w; else dut_b.mem[k] = w;
    end
  endtask

  function automatic logic [15:0] clamp(input longint v);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic verify(input int u, input int n, input string name);
    logic [79:0] exp, got;
    logic [15:0] m16, x16, y16;
    longint fa, fb, dx, dy, r2, p;
    for (int i = 0; i < n; i++) begin
      fa = 0; fb = 0;
      for (int j = 0; j < n; j++) begin
        if (j != i) begin
          dx = longint'(bx[j]) - bx[i];
          dy = longint'(by[j]) - by[i];
          r2 = dx * dx + dy * dy + 1;
          p  = longint'(bm[i]) * bm[j];
          fa += (p * dx) / r2;
          fb += (p * dy) / r2;
        end
      end
      m16 = bm[i][15:0];
      x16 = bx[i][15:0];
      y16 = by[i][15:0];
      exp = {m16, x16, y16, clamp(fa), clamp(fb)};
      @(negedge clk);
      if (u == 0) addr_a = 15'(i); else addr_b = 15'(i);
      @(negedge clk);
      got = (u == 0) ? q_a : q_b;
      check($sformatf("%s u%0d addr%0d", name, u, i), got, exp);
    end
  endtask

  // Start a pass and wait for done; optionally pulse start again mid-pass
  task automatic run(input int u, input bit midstart);
    int cnt;
    @(negedge clk);
    set_start(u, 1'b1);
    @(negedge clk);
    set_start(u, 1'b0);
    check("done_clear", {79'd0, get_done(u)}, 80'd0);
    cnt = 0;
    while (!get_done(u) && cnt < 2000) begin
      @(negedge clk);
      if (midstart && cnt == 6) set_start(u, 1'b1);
      else set_start(u, 1'b0);
      cnt++;
    end
    set_start(u, 1'b0);
    if (cnt >= 2000) check("done_timeout", 80'd0, 80'd1);
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    addr_a = '0; addr_b = '0;
    repeat (3) @(negedge clk);
    check("rst_done_a", {79'd0, done_a}, 80'd0);
    check("rst_done_b", {79'd0, done_b}, 80'd0);
    reset = 1'b0;

    // Classic 3-4-5 pair
    set_body(0, 10, 0, 0); set_body(1, 10, 3, 4);
    load(0, 2); run(0, 0); verify(0, 2, "pair345");
    addr_a = 15'd0; @(negedge clk); @(negedge clk);
    check("pair345_lit", {48'd0, q_a[31:0]}, {48'd0, 16'd11, 16'd15});

    // Idempotence: rerun without reloading
    run(0, 0); verify(0, 2, "rerun");

    // Coincident bodies
    set_body(0, 100, 5, 5); set_body(1, 100, 5, 5);
    load(0, 2); run(0, 0); verify(0, 2, "coincident");

    // Saturation both ways
    set_body(0, 65535, 0, 0); set_body(1, 65535, 1, 0);
    load(0, 2); run(0, 0); verify(0, 2, "saturate");

    // Collinear N=3
    set_body(0, 10, 0, 0); set_body(1, 10, 3, 0); set_body(2, 10, 6, 0);
    load(1, 3); run(1, 0); verify(1, 3, "collinear");
    addr_b = 15'd0; @(negedge clk); @(negedge clk);
    check("collinear_b0", {64'd0, q_b[31:16]}, 80'd46);

    // Second start mid-pass is ignored; done stays up afterwards
    load(1, 3); run(1, 1);
    repeat (20) @(negedge clk);
    check("single_done", {79'd0, done_b}, 80'd1);
    verify(1, 3, "midstart");

    // Reset mid-pass, then a fresh pass
    set_body(0, 10, 0, 0); set_body(1, 10, 3, 4);
    load(0, 2);
    @(negedge clk); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_done_a", {79'd0, done_a}, 80'd0);
    check("midrst_done_b", {79'd0, done_b}, 80'd0);
    reset = 1'b0;
    run(0, 0); verify(0, 2, "after_reset");

    // Random bodies, occasionally coincident
    for (int t = 0; t < 16; t++) begin
      int u, n;
      u = t % 2;
      n = (u == 0) ? 2 : 3;
      for (int k = 0; k < n; k++)
        set_body(k, int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768);
      if (t % 5 == 4) begin
        bx[1] = bx[0]; by[1] = by[0];
      end
      if (t % 3 == 2) begin
        for (int k = 1; k < n; k++) begin
          bx[k] = bx[0] + int'($urandom_range(0, 20)) - 10;
          by[k] = by[0] + int'($urandom_range(0, 20)) - 10;
          if (bx[k] > 32767) bx[k] = 32767;
          if (bx[k] < -32768) bx[k] = -32768;
          if (by[k] > 32767) by[k] = 32767;
          if (by[k] < -32768) by[k] = -32768;
        end
      end
      load(u, n); run(u, 0); verify(u, n, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
